// File: rtl/seq_countdown_arbiter_if.sv
// Handshake bundle between the per-channel requesters and the shared countdown arbiter.
// The requester side drives req/load_val; the arbiter drives grant, count and the completion pulses.
interface seq_countdown_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] load_val;
    logic [NREQ-1:0]       grant;
    logic                  busy;
    logic [WIDTH-1:0]      count;
    logic                  done;
    logic [IDW-1:0]        done_id;
    logic                  aborted;

    modport master (
        output req, load_val,
        input  grant, busy, count, done, done_id, aborted
    );

    modport slave (
        input  req, load_val,
        output grant, busy, count, done, done_id, aborted
    );
endinterface

// File: rtl/seq_countdown_arbiter.sv
// Round-robin arbiter that lends one shared down-counter to NREQ requesters.
// Reports done (or aborted) with the owner's id, then releases the counter.
module seq_countdown_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    seq_countdown_arbiter_if.slave  bus
);
    localparam int IDW = $clog2(NREQ);

    typedef enum logic {IDLE, COUNT} state_t;

    state_t           state_reg, state_next;
    logic [NREQ-1:0]  grant_reg, grant_next;
    logic [WIDTH-1:0] count_reg, count_next;
    logic             done_reg, done_next;
    logic             aborted_reg, aborted_next;
    logic [IDW-1:0]   done_id_reg, done_id_next;
    logic [IDW-1:0]   rr_ptr_reg, rr_ptr_next;
    logic [IDW-1:0]   owner_reg, owner_next;

    logic [WIDTH-1:0] load_slice [NREQ];
    logic             win_found;
    logic [IDW-1:0]   win_idx;
    logic [IDW:0]     cand;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
            assign load_slice[gi] = bus.load_val[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Scan upward from rr_ptr+1; the extra bit lets the sum wrap without overflow.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, rr_ptr_reg} + (IDW+1)'(k) + (IDW+1)'(1);
            if (cand >= (IDW+1)'(NREQ)) begin
                cand = cand - (IDW+1)'(NREQ);
            end
            if (!win_found && bus.req[cand[IDW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IDW-1:0];
            end
        end
    end

    always_comb begin
        state_next   = state_reg;
        grant_next   = grant_reg;
        count_next   = count_reg;
        done_next    = 1'b0;
        aborted_next = 1'b0;
        done_id_next = done_id_reg;
        rr_ptr_next  = rr_ptr_reg;
        owner_next   = owner_reg;
        case (state_reg)
            IDLE: begin
                if (win_found) begin
                    state_next = COUNT;
                    grant_next = NREQ'(1) << win_idx;
                    count_next = load_slice[win_idx];
                    owner_next = win_idx;
                end
            end
            COUNT: begin
                // A dropped request takes precedence even on the final zero cycle.
                if (!bus.req[owner_reg]) begin
                    state_next   = IDLE;
                    aborted_next = 1'b1;
                    done_id_next = owner_reg;
                    count_next   = '0;
                    grant_next   = '0;
                    rr_ptr_next  = owner_reg;
                end else if (count_reg == '0) begin
                    state_next   = IDLE;
                    done_next    = 1'b1;
                    done_id_next = owner_reg;
                    grant_next   = '0;
                    rr_ptr_next  = owner_reg;
                end else begin
                    count_next = count_reg - WIDTH'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            grant_reg   <= '0;
            count_reg   <= '0;
            done_reg    <= 1'b0;
            aborted_reg <= 1'b0;
            done_id_reg <= '0;
            rr_ptr_reg  <= IDW'(NREQ - 1);
            owner_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            grant_reg   <= grant_next;
            count_reg   <= count_next;
            done_reg    <= done_next;
            aborted_reg <= aborted_next;
            done_id_reg <= done_id_next;
            rr_ptr_reg  <= rr_ptr_next;
            owner_reg   <= owner_next;
        end
    end

    assign bus.grant   = grant_reg;
    assign bus.busy    = (state_reg == COUNT);
    assign bus.count   = count_reg;
    assign bus.done    = done_reg;
    assign bus.aborted = aborted_reg;
    assign bus.done_id = done_id_reg;
endmodule

// File: tb/tb_seq_countdown_arbiter.sv
// Directed and randomized checks of seq_countdown_arbiter against a cycle-count based model
// that derives the expected counter value from the grant time and the loaded value.
module tb_seq_countdown_arbiter;
    localparam int NREQ  = 4;
    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seq_countdown_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus();

    seq_countdown_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests_run = 0;
    int tests_failed = 0;

    // Model: owner, grant edge number and start value; count = start - edges elapsed.
    int cyc = 0;
    bit m_busy;
    int m_owner, m_start, m_val, m_rr, m_hold, m_id;
    bit m_done, m_ab;
    int done_q[$];
    int done_seen, abort_seen;
    int done_at, t0, lim;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_owner = 0; m_start = 0; m_val = 0;
        m_rr = NREQ - 1; m_hold = 0; m_id = 0; m_done = 0; m_ab = 0;
    endtask

    task automatic set_lv(input int i, input int v);
        bus.load_val[i*WIDTH +: WIDTH] = WIDTH'(v);
    endtask

    task automatic step();
        logic [NREQ-1:0]       r;
        logic [NREQ*WIDTH-1:0] lv;
        logic                  rs;
        int                    cur, idx;
        bit                    found;
        logic [NREQ-1:0]       eg;
        r = bus.req; lv = bus.load_val; rs = rst;
        @(posedge clk);
        if (rs) begin
            model_reset();
        end else if (!m_busy) begin
            m_done = 0; m_ab = 0; found = 0;
            for (int k = 1; k <= NREQ; k++) begin
                idx = (m_rr + k) % NREQ;
                if (!found && r[idx]) begin
                    found = 1; m_busy = 1; m_owner = idx; m_start = cyc + 1;
                    m_val = int'(lv[idx*WIDTH +: WIDTH]);
                end
            end
        end else begin
            cur = m_val - (cyc - m_start);
            if (!r[m_owner]) begin
                m_ab = 1; m_id = m_owner; m_busy = 0; m_hold = 0; m_rr = m_owner;
            end else if (cur == 0) begin
                m_done = 1; m_id = m_owner; m_busy = 0; m_hold = 0; m_rr = m_owner;
            end
        end
        cyc++;
        #1;
        eg = m_busy ? NREQ'(1) << m_owner : '0;
        chk("grant",   32'(bus.grant),   32'(eg));
        chk("busy",    32'(bus.busy),    32'(m_busy));
        chk("count",   32'(bus.count),   m_busy ? 32'(m_val - (cyc - m_start)) : 32'(m_hold));
        chk("done",    32'(bus.done),    32'(m_done));
        chk("aborted", 32'(bus.aborted), 32'(m_ab));
        chk("done_id", 32'(bus.done_id), 32'(m_id));
        chk("excl",    32'(bus.done & bus.aborted), 32'(0));
        chk("onehot0", 32'($onehot0(bus.grant)), 32'(1));
        if (bus.busy) chk("no_overshoot", 32'(int'(bus.count) <= m_val), 32'(1));
        if (bus.done) begin done_q.push_back(int'(bus.done_id)); done_seen++; end
        if (bus.aborted) abort_seen++;
    endtask

    task automatic do_reset();
        rst = 1'b1; bus.req = '0;
        step(); step();
        rst = 1'b0;
    endtask

    // Runs until done is seen, at most lim cycles; records the cycle or -1.
    task automatic run_to_done(input int limit, output int at);
        at = -1;
        for (int i = 0; i < limit && at < 0; i++) begin
            step();
            if (bus.done) at = cyc;
        end
    endtask

    initial begin
        rst = 1'b1; bus.req = '0; bus.load_val = '0;
        model_reset();
        step(); step();
        chk("rst_count", 32'(bus.count), 32'(0));
        chk("rst_grant", 32'(bus.grant), 32'(0));
        rst = 1'b0;

        // Single requester, value 3: done 5 cycles after req is sampled.
        bus.req = 4'b0001; set_lv(0, 3); t0 = cyc;
        run_to_done(20, done_at);
        chk("t1_done_lat", 32'(done_at - t0), 32'(5));
        chk("t1_done_id", 32'(bus.done_id), 32'(0));
        bus.req = '0; step(); step();

        // All four requesting with value 1: round-robin order 0,1,2,3,0.
        do_reset();
        for (int i = 0; i < NREQ; i++) set_lv(i, 1);
        done_q.delete();
        bus.req = 4'b1111;
        for (int i = 0; i < 15; i++) step();
        chk("t2_ndone", 32'(done_q.size() >= 5), 32'(1));
        for (int i = 0; i < 5; i++) chk("t2_order", 32'(done_q.size() > i ? done_q[i] : -1), 32'(i % NREQ));
        bus.req = '0; step(); step(); step();

        // Load value zero: done two cycles after sampling, no underflow.
        do_reset();
        set_lv(2, 0); bus.req = 4'b0100; t0 = cyc;
        run_to_done(10, done_at);
        chk("t3_done_lat", 32'(done_at - t0), 32'(2));
        chk("t3_count", 32'(bus.count), 32'(0));
        bus.req = '0; step();

        // Abort when count reaches 6.
        do_reset();
        set_lv(1, 10); bus.req = 4'b0010; done_seen = 0; abort_seen = 0;
        lim = 0;
        do begin step(); lim++; end while (!(bus.busy && bus.count == 8'd6) && lim < 20);
        chk("t4_reach6", 32'(bus.count), 32'(6));
        bus.req = '0; step();
        chk("t4_aborted", 32'(bus.aborted), 32'(1));
        chk("t4_id", 32'(bus.done_id), 32'(1));
        chk("t4_count", 32'(bus.count), 32'(0));
        step(); step();
        chk("t4_no_done", 32'(done_seen), 32'(0));
        chk("t4_one_abort", 32'(abort_seen), 32'(1));

        // Reset mid-countdown, then req0 and req3 together: req0 first.
        do_reset();
        set_lv(0, 9); bus.req = 4'b0001; lim = 0;
        do begin step(); lim++; end while (!(bus.busy && bus.count == 8'd4) && lim < 20);
        chk("t5_reach4", 32'(bus.count), 32'(4));
        rst = 1'b1; step();
        chk("t5_rst_done", 32'(bus.done), 32'(0));
        chk("t5_rst_busy", 32'(bus.busy), 32'(0));
        rst = 1'b0; bus.req = 4'b1001; set_lv(3, 2); step();
        chk("t5_grant0", 32'(bus.grant), 32'(4'b0001));
        bus.req = '0; step(); step();

        // Full-scale value 255: done 257 cycles after sampling.
        do_reset();
        set_lv(0, 255); bus.req = 4'b0001; t0 = cyc;
        run_to_done(300, done_at);
        chk("t6_done_lat", 32'(done_at - t0), 32'(257));
        bus.req = '0; step();

        // Random traffic with occasional aborts and resets.
        do_reset();
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 3) == 0) bus.req = NREQ'($urandom_range(0, 15));
            for (int j = 0; j < NREQ; j++) set_lv(j, int'($urandom_range(0, 6)));
            rst = ($urandom_range(0, 99) == 0);
            step();
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
